// File: rtl/axis_sink_pkg.sv
// Shared defaults and framing-state type for the AXI-Stream packet sink.
package axis_sink_pkg;

    localparam int AXIS_SINK_DATA_W = 32;
    localparam int AXIS_SINK_DEPTH  = 16;

    // Largest value the 16-bit running beat counter can hold.
    localparam logic [15:0] LEN_MAX = 16'hFFFF;

    // Framing state: between packets, or after at least one non-final beat.
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } sink_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// The head word is visible on rd_data whenever empty is low.
// A pop is only taken when the FIFO holds a word before the edge, so a push
// into an empty FIFO with rd_en high does not also pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;

    // Empty FIFO shows zero rather than stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_packet_sink.sv
// AXI-Stream packet sink: buffers beats in a FWFT FIFO and keeps per-packet
// length / XOR checksum statistics.
//
// Handshake: a beat transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high; tready depends only on registered FIFO
// occupancy, never on tvalid. On the read side a word pops on a rising edge
// where rd_en is high and rd_empty is low; rd_en while empty pops nothing
// and sets the sticky underflow flag.
module axis_packet_sink
    import axis_sink_pkg::*;
#(
    parameter int DATA_W = AXIS_SINK_DATA_W,
    parameter int DEPTH  = AXIS_SINK_DEPTH
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_empty,
    output logic              pkt_done,
    output logic [15:0]       last_len,
    output logic [DATA_W-1:0] last_csum,
    output logic [15:0]       pkt_count,
    output logic              underflow,
    output logic              state_dbg
);

    logic              fifo_full;
    logic              accept;
    sink_state_t       state;
    logic [15:0]       run_len;
    logic [DATA_W-1:0] run_xor;
    logic [15:0]       next_len;
    logic [DATA_W-1:0] next_xor;

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (s_axis_tvalid),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_data ({rd_last, rd_data}),
        .empty   (rd_empty),
        .full    (fifo_full)
    );

    assign s_axis_tready = !fifo_full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign state_dbg     = (state == IN_PKT);

    // Running totals including the current beat; a beat in IDLE starts fresh.
    always_comb begin
        next_len = 16'd1;
        next_xor = s_axis_tdata;
        if (state == IN_PKT) begin
            next_len = (run_len == LEN_MAX) ? LEN_MAX : run_len + 16'd1;
            next_xor = run_xor ^ s_axis_tdata;
        end
    end

    // Framing FSM plus registered packet statistics and flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            run_len   <= '0;
            run_xor   <= '0;
            last_len  <= '0;
            last_csum <= '0;
            pkt_count <= '0;
            pkt_done  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (rd_en && rd_empty) underflow <= 1'b1;
            if (accept) begin
                run_len <= next_len;
                run_xor <= next_xor;
                if (s_axis_tlast) begin
                    state     <= IDLE;
                    last_len  <= next_len;
                    last_csum <= next_xor;
                    pkt_count <= pkt_count + 16'd1;
                    pkt_done  <= 1'b1;
                end else begin
                    state <= IN_PKT;
                end
            end
        end
    end

endmodule
